// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage front end ahead of a doubleword-wide data memory.
// It turns RV64 byte-addressed loads and stores of 1/2/4/8 bytes into whole-doubleword
// accesses. Sub-doubleword stores use read-modify-write. Accesses that cross an 8-byte
// boundary use two doublewords. Load results are sign- or zero-extended.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only while idle)
//   req_write, req_funct3          store flag, RV access size/sign encoding
//   req_addr, req_wdata            byte address, store data (low bytes used)
//   resp_valid/resp_data/resp_err  one-cycle completion pulse, extended load data, error
//   mem_read_*/mem_write_*         doubleword memory ports (index = addr[63:3] + 1)
//   mem_read_data                  combinational read data, same cycle as the enable
module load_store_unit (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   req_valid,
   output logic                                   req_ready,
   input  logic                                   req_write,
   input  logic [2:0]                             req_funct3,
   input  logic [63:0]                            req_addr,
   input  logic [63:0]                            req_wdata,
   output logic                                   resp_valid,
   output logic [63:0]                            resp_data,
   output logic                                   resp_err,
   output logic                                   mem_read_enable,
   output logic                                   mem_write_enable,
   output logic [63:0]                            mem_read_addr,
   output logic [63:0]                            mem_write_addr,
   output logic [7:0][7:0]                        mem_write_data,
   input  logic [7:0][7:0]                        mem_read_data
);

   localparam int unsigned XLEN      = 64;
   localparam int unsigned BYTE_SIZE = 8;
   localparam int unsigned MEM_STEPS = XLEN / BYTE_SIZE;

   typedef enum logic [2:0] {S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_RESP} state_t;

   state_t                 r_state, w_next;
   logic [2:0]             r_funct3;
   logic [XLEN-1:0]        r_addr, r_wdata, r_dw0, r_dw1;
   logic                   r_write;
   logic                   r_req_ready, r_resp_valid, r_resp_err, r_rd_en, r_wr_en;
   logic [XLEN-1:0]        r_resp_data, r_rd_addr, r_wr_addr, r_wr_data;

   logic                   w_accept, w_write, w_cross, w_illegal, w_sign;
   logic [2:0]             w_funct3, w_off;
   logic [3:0]             w_size;
   logic [5:0]             w_sh;
   logic [XLEN-1:0]        w_addr, w_wdata, w_idx0, w_idx1, w_dw0, w_dw1;
   logic [XLEN-1:0]        w_lane_mask, w_raw, w_load;
   logic [2*XLEN-1:0]      w_mask128, w_merged;
   logic                   w_n_ready, w_n_rvalid, w_n_rerr, w_n_rd_en, w_n_wr_en;
   logic [XLEN-1:0]        w_n_rdata, w_n_rd_addr, w_n_wr_addr, w_n_wr_data;

   // While idle the live request describes the access; afterwards the captured copy does.
   assign w_accept  = (r_state == S_IDLE) && r_req_ready && req_valid;
   assign w_funct3  = (r_state == S_IDLE) ? req_funct3 : r_funct3;
   assign w_addr    = (r_state == S_IDLE) ? req_addr   : r_addr;
   assign w_wdata   = (r_state == S_IDLE) ? req_wdata  : r_wdata;
   assign w_write   = (r_state == S_IDLE) ? req_write  : r_write;

   assign w_off     = w_addr[2:0];
   assign w_size    = 4'd1 << w_funct3[1:0];
   assign w_cross   = (4'(w_off) + w_size) > 4'(MEM_STEPS);
   assign w_sh      = {w_off, 3'b000};
   assign w_idx0    = {3'b000, w_addr[XLEN-1:3]} + 64'd1;
   assign w_idx1    = w_idx0 + 64'd1;
   assign w_illegal = (w_funct3 == 3'b111) || (w_write && w_funct3[2]);

   // Read data is usable in the cycle it arrives as well as after it is captured.
   assign w_dw0     = (r_state == S_RD0) ? XLEN'(mem_read_data) : r_dw0;
   assign w_dw1     = (r_state == S_RD1) ? XLEN'(mem_read_data) : r_dw1;

   always_comb begin
      w_lane_mask = '1;
      case (w_funct3[1:0])
         2'b00:   w_lane_mask = 64'h0000_0000_0000_00FF;
         2'b01:   w_lane_mask = 64'h0000_0000_0000_FFFF;
         2'b10:   w_lane_mask = 64'h0000_0000_FFFF_FFFF;
         default: w_lane_mask = '1;
      endcase
   end

   // Store bytes laid over the 16-byte window {dw1, dw0}; other lanes keep read data.
   assign w_mask128 = {64'd0, w_lane_mask} << w_sh;
   assign w_merged  = ({w_dw1, w_dw0} & ~w_mask128) | (({64'd0, w_wdata} << w_sh) & w_mask128);

   // Load: align the addressed bytes to lane 0, then extend.
   assign w_raw  = XLEN'({w_dw1, w_dw0} >> w_sh);
   always_comb begin
      w_sign = 1'b0;
      w_load = w_raw;
      case (w_funct3[1:0])
         2'b00: begin
            w_sign = ~w_funct3[2] & w_raw[7];
            w_load = {{56{w_sign}}, w_raw[7:0]};
         end
         2'b01: begin
            w_sign = ~w_funct3[2] & w_raw[15];
            w_load = {{48{w_sign}}, w_raw[15:0]};
         end
         2'b10: begin
            w_sign = ~w_funct3[2] & w_raw[31];
            w_load = {{32{w_sign}}, w_raw[31:0]};
         end
         default: w_load = w_raw;
      endcase
   end

   // Next-state and next-output decode.
   always_comb begin
      w_next      = r_state;
      w_n_ready   = 1'b0;
      w_n_rvalid  = 1'b0;
      w_n_rerr    = 1'b0;
      w_n_rdata   = '0;
      w_n_rd_en   = 1'b0;
      w_n_rd_addr = '0;
      w_n_wr_en   = 1'b0;
      w_n_wr_addr = '0;
      w_n_wr_data = '0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_illegal)                                     w_next = S_RESP;
               else if (w_write && w_funct3 == 3'b011 && w_off == 3'd0) w_next = S_WR0;
               else                                               w_next = S_RD0;
            end
         end
         S_RD0:   w_next = w_cross ? S_RD1 : (w_write ? S_WR0 : S_RESP);
         S_RD1:   w_next = w_write ? S_WR0 : S_RESP;
         S_WR0:   w_next = w_cross ? S_WR1 : S_RESP;
         S_WR1:   w_next = S_RESP;
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase

      case (w_next)
         S_IDLE: w_n_ready = 1'b1;
         S_RD0: begin
            w_n_rd_en   = 1'b1;
            w_n_rd_addr = w_idx0;
         end
         S_RD1: begin
            w_n_rd_en   = 1'b1;
            w_n_rd_addr = w_idx1;
         end
         S_WR0: begin
            w_n_wr_en   = 1'b1;
            w_n_wr_addr = w_idx0;
            w_n_wr_data = w_merged[XLEN-1:0];
         end
         S_WR1: begin
            w_n_wr_en   = 1'b1;
            w_n_wr_addr = w_idx1;
            w_n_wr_data = w_merged[2*XLEN-1:XLEN];
         end
         S_RESP: begin
            w_n_rvalid = 1'b1;
            w_n_rerr   = w_illegal;
            w_n_rdata  = (w_illegal || w_write) ? '0 : w_load;
         end
         default: ;
      endcase
   end

   // State, capture and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_funct3     <= '0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_write      <= 1'b0;
         r_dw0        <= '0;
         r_dw1        <= '0;
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_data  <= '0;
         r_rd_en      <= 1'b0;
         r_rd_addr    <= '0;
         r_wr_en      <= 1'b0;
         r_wr_addr    <= '0;
         r_wr_data    <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_write  <= req_write;
         end
         if (r_state == S_RD0) r_dw0 <= XLEN'(mem_read_data);
         if (r_state == S_RD1) r_dw1 <= XLEN'(mem_read_data);
         r_req_ready  <= w_n_ready;
         r_resp_valid <= w_n_rvalid;
         r_resp_err   <= w_n_rerr;
         r_resp_data  <= w_n_rdata;
         r_rd_en      <= w_n_rd_en;
         r_rd_addr    <= w_n_rd_addr;
         r_wr_en      <= w_n_wr_en;
         r_wr_addr    <= w_n_wr_addr;
         r_wr_data    <= w_n_wr_data;
      end
   end

   assign req_ready        = r_req_ready;
   assign resp_valid       = r_resp_valid;
   assign resp_err         = r_resp_err;
   assign resp_data        = r_resp_data;
   assign mem_read_enable  = r_rd_en;
   assign mem_read_addr    = r_rd_addr;
   assign mem_write_enable = r_wr_en;
   assign mem_write_addr   = r_wr_addr;
   assign mem_write_data   = r_wr_data;

endmodule
